// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, single-outstanding req/ack memory port, decode queue
// Optional misaligned-target trap enabled by defining FETCH_MISALIGN_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          QUEUE_DEPTH  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_br_en,
  input  logic [31:0] i_br_addr,
  input  logic        i_stall,
  output logic        o_im_req,
  output logic [31:0] o_im_addr,
  input  logic        i_im_ack,
  input  logic [31:0] i_im_dat,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_misalign
);

  localparam int AW = (QUEUE_DEPTH > 2) ? 2 : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {IDLE, REQ, KILL} state_t;

  state_t        state, state_next;
  logic [31:0]   pc, pc_next;
  logic [31:0]   kill_addr, kill_addr_next;
  logic [31:0]   target;
  logic [31:0]   q_pc   [QUEUE_DEPTH];
  logic [31:0]   q_inst [QUEUE_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_next, count_push;
  logic          pop, push, flush, space;
  logic          br_ok, br_mis;
  logic          mis_q, mis_next;

  assign target     = {i_br_addr[31:2], 2'b00};
  assign br_ok      = i_br_en && !br_mis;
  assign flush      = i_br_en;
  assign pop        = o_valid && !i_stall;
  assign space      = (count < DEPTH_C) || pop;
  assign count_push = pop ? count : count + CNT_ONE;

`ifdef FETCH_MISALIGN_EN
  assign br_mis   = i_br_en && (i_br_addr[1:0] != 2'b00);
  assign mis_next = br_mis ? 1'b1 : (i_br_en ? 1'b0 : mis_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_next;
    end
  end
`else
  logic unused_br_low;
  assign unused_br_low = ^i_br_addr[1:0];
  assign br_mis        = 1'b0;
  assign mis_q         = 1'b0;
  assign mis_next      = 1'b0;
`endif

  assign o_misalign = mis_q;

  always_comb begin
    state_next     = state;
    pc_next        = pc;
    kill_addr_next = kill_addr;
    push           = 1'b0;
    o_im_req       = 1'b0;
    case (state)
      IDLE: begin
        if (br_ok) begin
          pc_next    = target;
          state_next = REQ;
        end else if (!br_mis && space && !mis_q) begin
          state_next = REQ;
        end
      end
      REQ: begin
        o_im_req       = 1'b1;
        kill_addr_next = pc;
        if (br_ok) begin
          pc_next    = target;
          state_next = i_im_ack ? REQ : KILL;
        end else if (br_mis) begin
          state_next = i_im_ack ? IDLE : KILL;
        end else if (i_im_ack) begin
          push       = 1'b1;
          pc_next    = pc + 32'd4;
          state_next = (count_push < DEPTH_C) ? REQ : IDLE;
        end
      end
      KILL: begin
        // The old request stays on the bus until memory answers; its data is dropped.
        o_im_req = 1'b1;
        if (br_ok) begin
          pc_next = target;
        end
        if (i_im_ack) begin
          state_next = mis_next ? IDLE : REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_im_addr = (state == KILL) ? kill_addr : pc;

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + CNT_ONE;
    end else if (pop && !push) begin
      count_next = count - CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      pc        <= RESET_VECTOR;
      kill_addr <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      kill_addr <= kill_addr_next;
      count     <= count_next;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          q_pc[wr_ptr]   <= pc;
          q_inst[wr_ptr] <= i_im_dat;
          wr_ptr         <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
      end
    end
  end

  assign o_valid = (count != '0);
  assign o_pc    = o_valid ? q_pc[rd_ptr] : '0;
  assign o_inst  = o_valid ? q_inst[rd_ptr] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_br_en = 1'b0;
  logic [31:0] i_br_addr = '0;
  logic        i_stall = 1'b0;
  logic        o_im_req;
  logic [31:0] o_im_addr;
  logic        i_im_ack;
  logic [31:0] i_im_dat;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_inst;
  logic        o_misalign;

  int checks = 0;
  int fails  = 0;
  logic [3:0] lat = '0;
  logic [3:0] wcnt;

  fetch_unit dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_br_en(i_br_en), .i_br_addr(i_br_addr),
    .i_stall(i_stall), .o_im_req(o_im_req), .o_im_addr(o_im_addr),
    .i_im_ack(i_im_ack), .i_im_dat(i_im_dat), .o_valid(o_valid), .o_pc(o_pc),
    .o_inst(o_inst), .o_misalign(o_misalign)
  );

  always #5 i_clk = ~i_clk;

  // Memory answers after lat wait cycles; lat = 0 acks in the cycle req rises.
  assign i_im_ack = o_im_req && (wcnt >= lat);
  assign i_im_dat = o_im_addr ^ 32'hDEAD_0000;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) wcnt <= '0;
    else if (o_im_req && i_im_ack) wcnt <= '0;
    else if (o_im_req) wcnt <= wcnt + 4'd1;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic do_reset;
    i_rst_n = 1'b0; i_br_en = 1'b0; i_br_addr = '0; i_stall = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset;
    lat = 4'd0;
    i_rst_n = 1'b0;
    @(negedge i_clk);
    checks++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_im_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b expected 0", o_im_req); end
    checks++; if (o_pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h expected 00000000", o_pc); end
    checks++; if (o_inst !== 32'h0) begin fails++; $display("FAIL reset_inst: got %h expected 00000000", o_inst); end
    checks++; if (o_misalign !== 1'b0) begin fails++; $display("FAIL reset_misalign: got %b expected 0", o_misalign); end
    // Reset in the middle of a slow request drops it immediately.
    lat = 4'd5;
    do_reset;
    repeat (2) @(negedge i_clk);
    checks++; if (o_im_req !== 1'b1) begin fails++; $display("FAIL midreq_req_up: got %b expected 1", o_im_req); end
    #2 i_rst_n = 1'b0;
    #1;
    checks++; if (o_im_req !== 1'b0) begin fails++; $display("FAIL midreq_abandon: got %b expected 0", o_im_req); end
    @(negedge i_clk);
  endtask

  task automatic test_stream;
    lat = 4'd0;
    do_reset;
    checks++; if (o_im_req !== 1'b0) begin fails++; $display("FAIL stream_idle_req: got %b expected 0", o_im_req); end
    @(negedge i_clk);
    checks++; if (o_im_req !== 1'b1 || o_im_addr !== 32'h0) begin fails++; $display("FAIL stream_addr0: got req %b addr %h expected 1 00000000", o_im_req, o_im_addr); end
    checks++; if (o_valid !== 1'b0) begin fails++; $display("FAIL stream_valid_c1: got %b expected 0", o_valid); end
    @(negedge i_clk);
    checks++; if (o_im_addr !== 32'h4) begin fails++; $display("FAIL stream_addr4: got %h expected 00000004", o_im_addr); end
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_inst !== mem_word(32'h0)) begin fails++; $display("FAIL stream_head0: got v %b pc %h inst %h expected 1 00000000 %h", o_valid, o_pc, o_inst, mem_word(32'h0)); end
    @(negedge i_clk);
    checks++; if (o_im_addr !== 32'h8) begin fails++; $display("FAIL stream_addr8: got %h expected 00000008", o_im_addr); end
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h4) begin fails++; $display("FAIL stream_head4: got v %b pc %h expected 1 00000004", o_valid, o_pc); end
  endtask

  task automatic test_stall;
    lat = 4'd0;
    do_reset;
    repeat (2) @(negedge i_clk);
    i_stall = 1'b1;
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0) begin fails++; $display("FAIL stall_first: got v %b pc %h expected 1 00000000", o_valid, o_pc); end
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      checks++; if (o_im_req !== 1'b0 || o_valid !== 1'b1 || o_pc !== 32'h0) begin fails++; $display("FAIL stall_hold: cycle %0d got req %b v %b pc %h expected 0 1 00000000", k, o_im_req, o_valid, o_pc); end
    end
    i_stall = 1'b0;
    @(negedge i_clk);
    checks++; if (o_pc !== 32'h4 || o_valid !== 1'b1) begin fails++; $display("FAIL stall_release_pc: got v %b pc %h expected 1 00000004", o_valid, o_pc); end
    checks++; if (o_im_req !== 1'b1 || o_im_addr !== 32'h8) begin fails++; $display("FAIL stall_release_req: got req %b addr %h expected 1 00000008", o_im_req, o_im_addr); end
  endtask

  task automatic test_branch_late;
    bit found;
    lat = 4'd3;
    do_reset;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge i_clk);
      if (o_im_req && o_im_addr == 32'h8) found = 1'b1;
    end
    checks++; if (!found) begin fails++; $display("FAIL late_reach8: got timeout expected request at 00000008"); end
    @(negedge i_clk);
    i_br_en = 1'b1; i_br_addr = 32'h100;
    checks++; if (i_im_ack !== 1'b0) begin fails++; $display("FAIL late_no_ack: got %b expected 0", i_im_ack); end
    @(negedge i_clk);
    i_br_en = 1'b0;
    checks++; if (o_im_req !== 1'b1 || o_im_addr !== 32'h8 || o_valid !== 1'b0) begin fails++; $display("FAIL late_kill_hold: got req %b addr %h v %b expected 1 00000008 0", o_im_req, o_im_addr, o_valid); end
    @(negedge i_clk);
    checks++; if (o_im_addr !== 32'h8 || i_im_ack !== 1'b1) begin fails++; $display("FAIL late_kill_ack: got addr %h ack %b expected 00000008 1", o_im_addr, i_im_ack); end
    @(negedge i_clk);
    checks++; if (o_im_req !== 1'b1 || o_im_addr !== 32'h100 || o_valid !== 1'b0) begin fails++; $display("FAIL late_redirect: got req %b addr %h v %b expected 1 00000100 0", o_im_req, o_im_addr, o_valid); end
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge i_clk);
      if (o_valid) found = 1'b1;
    end
    checks++; if (!found || o_pc !== 32'h100 || o_inst !== mem_word(32'h100)) begin fails++; $display("FAIL late_first_head: got found %b pc %h inst %h expected 1 00000100 %h", found, o_pc, o_inst, mem_word(32'h100)); end
  endtask

  task automatic test_branch_ack_pop;
    lat = 4'd0;
    do_reset;
    repeat (2) @(negedge i_clk);
    checks++; if (o_valid !== 1'b1 || i_im_ack !== 1'b1) begin fails++; $display("FAIL bap_setup: got v %b ack %b expected 1 1", o_valid, i_im_ack); end
    i_br_en = 1'b1; i_br_addr = 32'h40;
    @(negedge i_clk);
    i_br_en = 1'b0;
    checks++; if (o_valid !== 1'b0) begin fails++; $display("FAIL bap_flush: got %b expected 0", o_valid); end
    checks++; if (o_im_req !== 1'b1 || o_im_addr !== 32'h40) begin fails++; $display("FAIL bap_addr: got req %b addr %h expected 1 00000040", o_im_req, o_im_addr); end
    @(negedge i_clk);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h40 || o_inst !== mem_word(32'h40)) begin fails++; $display("FAIL bap_head40: got v %b pc %h inst %h expected 1 00000040 %h", o_valid, o_pc, o_inst, mem_word(32'h40)); end
    @(negedge i_clk);
    checks++; if (o_pc !== 32'h44) begin fails++; $display("FAIL bap_head44: got %h expected 00000044", o_pc); end
  endtask

  task automatic test_wrap;
    lat = 4'd0;
    do_reset;
    i_br_en = 1'b1; i_br_addr = 32'hFFFF_FFFC;
    @(negedge i_clk);
    i_br_en = 1'b0;
    checks++; if (o_im_req !== 1'b1 || o_im_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_top: got req %b addr %h expected 1 fffffffc", o_im_req, o_im_addr); end
    @(negedge i_clk);
    checks++; if (o_im_addr !== 32'h0 || o_pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_zero: got addr %h pc %h expected 00000000 fffffffc", o_im_addr, o_pc); end
    @(negedge i_clk);
    checks++; if (o_im_addr !== 32'h4 || o_pc !== 32'h0) begin fails++; $display("FAIL wrap_next: got addr %h pc %h expected 00000004 00000000", o_im_addr, o_pc); end
  endtask

  task automatic test_misalign;
    lat = 4'd0;
    do_reset;
`ifdef FETCH_MISALIGN_EN
    repeat (2) @(negedge i_clk);
    i_br_en = 1'b1; i_br_addr = 32'h102;
    @(negedge i_clk);
    i_br_en = 1'b0;
    checks++; if (o_misalign !== 1'b1 || o_valid !== 1'b0) begin fails++; $display("FAIL mis_set: got mis %b v %b expected 1 0", o_misalign, o_valid); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_im_req !== 1'b0) begin fails++; $display("FAIL mis_noreq: cycle %0d got %b expected 0", k, o_im_req); end
      @(negedge i_clk);
    end
    i_br_en = 1'b1; i_br_addr = 32'h200;
    @(negedge i_clk);
    i_br_en = 1'b0;
    checks++; if (o_misalign !== 1'b0 || o_im_req !== 1'b1 || o_im_addr !== 32'h200) begin fails++; $display("FAIL mis_clear: got mis %b req %b addr %h expected 0 1 00000200", o_misalign, o_im_req, o_im_addr); end
`else
    i_br_en = 1'b1; i_br_addr = 32'h102;
    @(negedge i_clk);
    i_br_en = 1'b0;
    checks++; if (o_misalign !== 1'b0 || o_im_req !== 1'b1 || o_im_addr !== 32'h100) begin fails++; $display("FAIL mis_drop_low: got mis %b req %b addr %h expected 0 1 00000100", o_misalign, o_im_req, o_im_addr); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_branch_late;
    test_branch_ack_pop;
    test_wrap;
    test_misalign;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
